os_core_ctrl: RTL
=================

OS_CORE_CTRL -- requirements
Module: os_core_ctrl

Interface
REQ-001 Parameter ROW, default 8: PE array rows; sets flush length.
REQ-002 Parameter ADDR_W, default 11: xmem/pmem address width.
REQ-003 Parameter W_BASE, default 11'h400: xmem base address of the weight region.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; accepted only in IDLE.
REQ-007 cfg_ic  in  4  number of input channels (1..15).
REQ-008 cfg_nij  in  8  activation rows per channel (1..255).
REQ-009 cfg_kij  in  8  weight rows per channel (1..255).
REQ-010 cfg_onij  in  8  output rows to drain (1..255).
REQ-011 ofifo_valid  in  1  core OFIFO holds a full row.
REQ-012 inst  out  36  registered core instruction word.
  Bit map: [35] output_en, [34] mode, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on leaving PMEM_WR.

Function
REQ-015 The block latches cfg_* on the start cycle; later cfg changes are ignored until the next start.
REQ-016 FSM states: IDLE, ACT_L0, W_FIFO, EXEC, FLUSH, DRAIN, OFIFO_WAIT, PMEM_WR.
  Transitions: IDLE -start-> ACT_L0 -> W_FIFO -> EXEC -> FLUSH; FLUSH -> ACT_L0 if ic < cfg_ic-1, else DRAIN; DRAIN -> OFIFO_WAIT -> PMEM_WR -> IDLE.
REQ-017 Fixed bits in every state: mode=1, acc=0, load=0, WEN_xmem=1.
  Default (inactive) values: CEN_xmem=1, CEN_pmem=1, WEN_pmem=1, all strobes 0.
REQ-018 ACT_L0 lasts cfg_nij+1 cycles.
  - CEN_xmem=0 for the first cfg_nij cycles.
  - A_xmem = ic*cfg_nij + k, k = 0..cfg_nij-1.
  - l0_wr=1 on cycles 1..cfg_nij (one cycle after each address, matching the 1-cycle SRAM read latency).
REQ-019 W_FIFO follows the same shape as ACT_L0: A_xmem = W_BASE + ic*cfg_kij + k, ififo_wr lagging by one cycle, cfg_kij+1 cycles.
REQ-020 EXEC lasts cfg_nij+2 cycles.
  - l0_rd=1 and ififo_rd=1 on all cycles.
  - execute=1 on the first cfg_nij cycles only.
REQ-021 FLUSH lasts 2*ROW-1 cycles with all strobes low; ic increments on its final cycle.
REQ-022 DRAIN lasts cfg_onij+1 cycles with output_en=1.
REQ-023 OFIFO_WAIT holds until ofifo_valid=1; there is no timeout.
REQ-024 PMEM_WR lasts cfg_onij+1 cycles.
  - ofifo_rd=1 for the first cfg_onij cycles.
  - CEN_pmem=0 and WEN_pmem=0 on cycles 1..cfg_onij.
  - A_pmem = cfg_onij-1 down to 0, lagging ofifo_rd by one cycle.
REQ-025 Address arithmetic is ADDR_W bits; the product ic*cfg_nij wraps modulo 2^ADDR_W, and no overflow is flagged.
REQ-026 A start pulse while busy is ignored.
  A start coincident with the done cycle is also ignored; a new run needs start in IDLE.
REQ-027 All outputs are registered; inst reflects the current state with zero added latency beyond that register.

Reset
REQ-028 While reset=1, on the next edge:
  - state=IDLE; all counters 0.
  - inst = default word: bits 32,31,19,18 =1; bit 34 =1; all else 0.
  - busy=0, done=0.
REQ-029 Reset asserted mid-run aborts the run within one cycle; no partial done is issued.

Structure
REQ-030 A shared package os_ctrl_pkg holds the FSM state enum, the inst bit-index constants and the default inst word.
REQ-031 One sub-module, os_addr_gen, holds the base/offset/step counter used by ACT_L0, W_FIFO and PMEM_WR.

Verification
REQ-032 cfg_ic=1, nij=9, kij=9, onij=8, start:
  - l0_wr high 9 cycles with A_xmem 0..8.
  - ififo_wr high 9 cycles with A_xmem 0x400..0x408.
  - execute high 9 cycles.
  - done after ofifo_valid, with 8 pmem writes at A_pmem 7..0.
REQ-033 cfg_ic=3: the second channel's ACT_L0 starts at A_xmem 9 and W_FIFO at 0x409; FLUSH count is 15 cycles each pass.
REQ-034 ofifo_valid held low 20 cycles: the block stays in OFIFO_WAIT with ofifo_rd=0; it writes once ofifo_valid goes high.
REQ-035 Reset pulsed during EXEC: the next cycle shows the default inst word, busy=0, and no done pulse.
REQ-036 Start pulses while busy and on the done cycle: no second run begins; busy falls after done.
REQ-037 cfg_nij=1, cfg_onij=1 minimum lengths: exactly one l0_wr, one execute and one pmem write, at A_pmem 0.

Source files
------------

// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the output-stationary core controller: FSM states,
// bit positions inside the 36-bit core instruction word and its idle value.
package os_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT_L0,
        S_W_FIFO,
        S_EXEC,
        S_FLUSH,
        S_DRAIN,
        S_OFIFO_WAIT,
        S_PMEM_WR
    } state_t;

    localparam int INST_W    = 36;
    localparam int A_FIELD_W = 11;

    localparam int B_OUT_EN   = 35;
    localparam int B_MODE     = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Idle word: mode=1, both memories deselected and write-disabled,
    // every strobe and address field zero.
    localparam logic [INST_W-1:0] INST_DEF = 36'h5800C0000;

endpackage

// File: rtl/os_addr_gen.sv
// Address counter shared by the memory-streaming phases: loads a base,
// then holds or steps up/down by one each cycle. The next value is exposed
// so the caller can register it into the instruction word in the same cycle.
module os_addr_gen #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_nxt_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // Load has priority over stepping; arithmetic wraps at ADDR_W bits.
    always_comb begin
        addr_d = addr_q;
        if (load_i)
            addr_d = base_i;
        else if (step_i)
            addr_d = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end

    // Address register.
    always_ff @(posedge clk) begin
        if (reset) addr_q <= '0;
        else       addr_q <= addr_d;
    end

    assign addr_nxt_o = addr_d;

endmodule

// File: rtl/os_core_ctrl.sv
// Sequencer for the output-stationary PE core: per input channel it fills L0
// with activations, the IFIFO with weights, executes and flushes the array,
// then drains the OFIFO rows into pmem. The instruction word is computed from
// the next state so the registered inst always matches the current state.
module os_core_ctrl
    import os_ctrl_pkg::*;
#(
    parameter int              ROW    = 8,
    parameter int              ADDR_W = 11,
    parameter logic [ADDR_W-1:0] W_BASE = ADDR_W'('h400)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cfg_ic,
    input  logic [7:0]        cfg_nij,
    input  logic [7:0]        cfg_kij,
    input  logic [7:0]        cfg_onij,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    // Wide enough for 255+1 phase cycles and for the flush length.
    localparam int CW = ($clog2(2*ROW) > 9) ? $clog2(2*ROW) : 9;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2*ROW-2);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        ic_q, ic_d;
    logic [3:0]        cfg_ic_q, cfg_ic_d;
    logic [7:0]        cfg_nij_q, cfg_nij_d;
    logic [7:0]        cfg_kij_q, cfg_kij_d;
    logic [7:0]        cfg_onij_q, cfg_onij_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ag_load, ag_step, ag_down;
    logic [ADDR_W-1:0] ag_base, ag_addr;
    logic [CW-1:0]     nij_c, kij_c, onij_c;

    // Configuration is captured only when a run is accepted.
    always_comb begin
        cfg_ic_d   = cfg_ic_q;
        cfg_nij_d  = cfg_nij_q;
        cfg_kij_d  = cfg_kij_q;
        cfg_onij_d = cfg_onij_q;
        if (state_q == S_IDLE && start) begin
            cfg_ic_d   = cfg_ic;
            cfg_nij_d  = cfg_nij;
            cfg_kij_d  = cfg_kij;
            cfg_onij_d = cfg_onij;
        end
    end

    assign nij_c  = CW'(cfg_nij_d);
    assign kij_c  = CW'(cfg_kij_d);
    assign onij_c = CW'(cfg_onij_d);

    // Next state, phase cycle counter and channel index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        ic_d    = ic_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ACT_L0;
                    ic_d    = '0;
                end
            end
            S_ACT_L0:
                if (cnt_q == nij_c) begin state_d = S_W_FIFO; cnt_d = '0; end
            S_W_FIFO:
                if (cnt_q == kij_c) begin state_d = S_EXEC; cnt_d = '0; end
            S_EXEC:
                if (cnt_q == nij_c + CW'(1)) begin state_d = S_FLUSH; cnt_d = '0; end
            S_FLUSH:
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    ic_d    = ic_q + 4'd1;
                    state_d = ({1'b0, ic_q} + 5'd1 < {1'b0, cfg_ic_q}) ? S_ACT_L0 : S_DRAIN;
                end
            S_DRAIN:
                if (cnt_q == onij_c) begin state_d = S_OFIFO_WAIT; cnt_d = '0; end
            S_OFIFO_WAIT: begin
                cnt_d = '0;
                if (ofifo_valid) state_d = S_PMEM_WR;
            end
            S_PMEM_WR:
                if (cnt_q == onij_c) begin state_d = S_IDLE; cnt_d = '0; end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Address sequencing: activations at ic*nij, weights at W_BASE+ic*kij,
    // pmem rows written from onij-1 downward one cycle behind ofifo_rd.
    always_comb begin
        ag_load = 1'b0;
        ag_step = 1'b0;
        ag_down = 1'b0;
        ag_base = '0;
        case (state_d)
            S_ACT_L0: begin
                ag_base = ADDR_W'(ic_d) * ADDR_W'(cfg_nij_d);
                ag_load = (cnt_d == '0);
                ag_step = (cnt_d != '0);
            end
            S_W_FIFO: begin
                ag_base = W_BASE + ADDR_W'(ic_d) * ADDR_W'(cfg_kij_d);
                ag_load = (cnt_d == '0);
                ag_step = (cnt_d != '0);
            end
            S_PMEM_WR: begin
                ag_base = ADDR_W'(cfg_onij_d) - ADDR_W'(1);
                ag_load = (cnt_d == '0);
                ag_step = (cnt_d > CW'(1));
                ag_down = 1'b1;
            end
            default: ;
        endcase
    end

    os_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ag_load),
        .base_i     (ag_base),
        .step_i     (ag_step),
        .down_i     (ag_down),
        .addr_nxt_o (ag_addr)
    );

    // Instruction word for the state being entered; SRAM read data lands one
    // cycle after its address, so the write strobes lag by one cycle.
    always_comb begin
        inst_d = INST_DEF;
        case (state_d)
            S_ACT_L0: begin
                inst_d[B_CEN_X] = !(cnt_d < nij_c);
                inst_d[B_AX_LO +: A_FIELD_W] = A_FIELD_W'(ag_addr);
                inst_d[B_L0_WR] = (cnt_d != '0);
            end
            S_W_FIFO: begin
                inst_d[B_CEN_X] = !(cnt_d < kij_c);
                inst_d[B_AX_LO +: A_FIELD_W] = A_FIELD_W'(ag_addr);
                inst_d[B_IFIFO_WR] = (cnt_d != '0);
            end
            S_EXEC: begin
                inst_d[B_L0_RD]    = 1'b1;
                inst_d[B_IFIFO_RD] = 1'b1;
                inst_d[B_EXEC]     = (cnt_d < nij_c);
            end
            S_DRAIN:
                inst_d[B_OUT_EN] = 1'b1;
            S_PMEM_WR: begin
                inst_d[B_OFIFO_RD] = (cnt_d < onij_c);
                inst_d[B_CEN_P]    = (cnt_d == '0);
                inst_d[B_WEN_P]    = (cnt_d == '0);
                inst_d[B_AP_LO +: A_FIELD_W] = A_FIELD_W'(ag_addr);
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_PMEM_WR) && (cnt_d == onij_c);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ic_q       <= '0;
            cfg_ic_q   <= '0;
            cfg_nij_q  <= '0;
            cfg_kij_q  <= '0;
            cfg_onij_q <= '0;
            inst_q     <= INST_DEF;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ic_q       <= ic_d;
            cfg_ic_q   <= cfg_ic_d;
            cfg_nij_q  <= cfg_nij_d;
            cfg_kij_q  <= cfg_kij_d;
            cfg_onij_q <= cfg_onij_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
